// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and
// small decode helpers used by both the sequencer and the ALU array.
package alu_sequencer_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_SHIFT = 2'b10
    } state_e;

    // True for the opcodes that are run iteratively by the shift engine.
    function automatic logic is_shift_op(input logic [3:0] op);
        logic res;
        case (op)
            ALU_SRL, ALU_SLL, ALU_SRA: res = 1'b1;
            default:                   res = 1'b0;
        endcase
        return res;
    endfunction

    // Subtract-style operations run the adder as a + ~b + 1.
    function automatic logic needs_invert(input logic [3:0] op, input logic sub);
        logic res;
        case (op)
            ALU_ADD:           res = sub;
            ALU_SLT, ALU_SLTU: res = 1'b1;
            default:           res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_nbits.sv
// WIDTH-slice ALU array. Each slice sees a, b (optionally inverted), its
// carry-in and a 'less' input; slice 0 receives the comparison outcome
// derived from the MSB set output (signed) or the carry-out (unsigned).
module alu_nbits
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_invert,
    input  logic             i_cin,
    input  logic [3:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_set
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_full;
    logic [WIDTH:0]   w_carry;
    logic             w_overflow;
    logic             w_less0;

    assign w_b_eff = i_invert ? ~i_b : i_b;
    assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_cin};

    // Carry into each slice recovered from the full sum; top bit is carry-out.
    assign w_carry[WIDTH] = w_full[WIDTH];
    for (genvar g = 0; g < WIDTH; g++) begin : g_carry
        assign w_carry[g] = w_full[g] ^ i_a[g] ^ w_b_eff[g];
    end

    assign w_overflow = w_carry[WIDTH-1] ^ w_carry[WIDTH];
    assign o_cout     = w_carry[WIDTH];
    assign o_set      = (i_a[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_carry[WIDTH-1]) ^ w_overflow;
    assign w_less0    = (i_op == ALU_SLT) ? o_set : ~o_cout;

    for (genvar g = 0; g < WIDTH; g++) begin : g_slice
        logic w_less;
        logic w_bit;

        assign w_less = (g == 0) ? w_less0 : 1'b0;

        // One bit slice: logic ops, sum bit, less pass-in or a pass-through.
        always_comb begin
            w_bit = 1'b0;
            case (i_op)
                ALU_AND:                   w_bit = i_a[g] & w_b_eff[g];
                ALU_OR:                    w_bit = i_a[g] | w_b_eff[g];
                ALU_XOR:                   w_bit = i_a[g] ^ w_b_eff[g];
                ALU_ADD:                   w_bit = i_a[g] ^ w_b_eff[g] ^ w_carry[g];
                ALU_SLT, ALU_SLTU:         w_bit = w_less;
                ALU_SRL, ALU_SLL, ALU_SRA: w_bit = i_a[g];
                default:                   w_bit = 1'b0;
            endcase
        end

        assign o_result[g] = w_bit;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller: single-cycle EXEC for array operations and an
// iterative one-bit-per-cycle shift engine for SRL/SLL/SRA.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] resultado_o,
    output logic             zero_o
);

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic             r_sub;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_invert;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_cout;
    logic             w_alu_set;
    logic [WIDTH-1:0] w_exec_result;
    logic [WIDTH-1:0] w_shift_next;

    assign w_invert = needs_invert(r_op, r_sub);

    alu_nbits #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_invert (w_invert),
        .i_cin    (w_invert),
        .i_op     (r_op),
        .o_result (w_alu_res),
        .o_cout   (w_alu_cout),
        .o_set    (w_alu_set)
    );

    // Pick the EXEC result; SLT/SLTU already come out of the array as {0..,less}.
    always_comb begin
        w_exec_result = {WIDTH{1'b0}};
        case (r_op)
            ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SLT, ALU_SLTU:
                w_exec_result = w_alu_res;
            default:
                w_exec_result = {WIDTH{1'b0}};
        endcase
    end

    // One-bit shift step of the working register for the latched opcode.
    always_comb begin
        w_shift_next = r_work;
        case (r_op)
            ALU_SRL: w_shift_next = {1'b0, r_work[WIDTH-1:1]};
            ALU_SLL: w_shift_next = {r_work[WIDTH-2:0], 1'b0};
            ALU_SRA: w_shift_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            default: w_shift_next = r_work;
        endcase
    end

    // Control FSM with registered busy/done/result/zero outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_op     <= 4'b0000;
            r_sub    <= 1'b0;
            r_work   <= {WIDTH{1'b0}};
            r_cnt    <= {SHW{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {WIDTH{1'b0}};
            r_zero   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_a    <= a_i;
                        r_b    <= b_i;
                        r_op   <= op_i;
                        r_sub  <= sub_i;
                        r_busy <= 1'b1;
                        if (is_shift_op(op_i)) begin
                            r_work  <= a_i;
                            r_cnt   <= b_i[SHW-1:0];
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state <= ST_EXEC;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    r_result <= w_exec_result;
                    r_zero   <= (w_exec_result == {WIDTH{1'b0}});
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                ST_SHIFT: begin
                    if (r_cnt != {SHW{1'b0}}) begin
                        r_work <= w_shift_next;
                        r_cnt  <= r_cnt - SHW'(1);
                    end else begin
                        r_result <= r_work;
                        r_zero   <= (r_work == {WIDTH{1'b0}});
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign resultado_o = r_result;
    assign zero_o      = r_zero;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table, random ops with a
// reference model, and hand sequences for reset, busy and back-to-back cases.
module tb_alu_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         start_i;
    logic [3:0]   op_i;
    logic         sub_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] resultado_o;
    logic         zero_o;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [3:0]   op;
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
    } sb_t;

    sb_t  sb_q[$];
    vec_t tbl[16];

    alu_sequencer #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .op_i        (op_i),
        .sub_i       (sub_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .resultado_o (resultado_o),
        .zero_o      (zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic sub,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = sub ? a - b : a + b;
            4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: r = a ^ b;
            4'd5: r = (a < b) ? 32'd1 : 32'd0;
            4'd6: r = a >> sh;
            4'd7: r = a << sh;
            4'd8: r = $signed(a) >>> sh;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic bit op_is_shift(input logic [3:0] op);
        return (op == 4'd6) || (op == 4'd7) || (op == 4'd8);
    endfunction

    // Issue one op, push the expectation, wait for done and compare.
    task automatic do_op(input vec_t v, input string name);
        sb_t e;
        sb_t got;
        int  cyc;
        e.res = v.exp;
        e.lat = op_is_shift(v.op) ? int'(v.b[4:0]) + 1 : 1;
        sb_q.push_back(e);
        op_i    = v.op;
        sub_i   = v.sub;
        a_i     = v.a;
        b_i     = v.b;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        a_i     = $urandom;
        b_i     = $urandom;
        op_i    = 4'($urandom_range(0, 15));
        sub_i   = ~sub_i;
        chk({name, " busy"}, {31'd0, busy_o}, 32'd1);
        cyc = 0;
        while (done_o !== 1'b1 && cyc < W + 5) begin
            @(posedge clk); #1;
            cyc++;
        end
        got = sb_q.pop_front();
        chk({name, " res"}, resultado_o, got.res);
        chk({name, " zero"}, {31'd0, zero_o}, {31'd0, (got.res == 32'd0)});
        chk({name, " lat"}, cyc, got.lat);
        chk({name, " busy_end"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        vec_t v;
        int   dones;
        int   first_done;
        logic [W-1:0] res_at_done;

        tbl[0]  = '{4'd2, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        tbl[1]  = '{4'd2, 1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000};
        tbl[2]  = '{4'd3, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        tbl[3]  = '{4'd5, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        tbl[4]  = '{4'd8, 1'b0, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF};
        tbl[5]  = '{4'd6, 1'b0, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
        tbl[6]  = '{4'd7, 1'b0, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
        tbl[7]  = '{4'd15, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};
        tbl[8]  = '{4'd0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};
        tbl[9]  = '{4'd1, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0};
        tbl[10] = '{4'd4, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00};
        tbl[11] = '{4'd3, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
        tbl[12] = '{4'd5, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        tbl[13] = '{4'd7, 1'b0, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
        tbl[14] = '{4'd8, 1'b0, 32'h4000_0000, 32'h0000_0024, 32'h0400_0000};
        tbl[15] = '{4'd0, 1'b1, 32'h0000_FFFF, 32'h00FF_00FF, 32'h0000_00FF};

        rst_ni  = 1'b0;
        start_i = 1'b0;
        op_i    = 4'd0;
        sub_i   = 1'b0;
        a_i     = 32'd0;
        b_i     = 32'd0;
        #12;
        chk("rst busy", {31'd0, busy_o}, 32'd0);
        chk("rst done", {31'd0, done_o}, 32'd0);
        chk("rst res", resultado_o, 32'd0);
        chk("rst zero", {31'd0, zero_o}, 32'd1);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            do_op(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 12; i++) begin
            v.op  = 4'($urandom_range(0, 9));
            v.sub = 1'($urandom_range(0, 1));
            v.a   = $urandom;
            v.b   = $urandom;
            v.exp = model(v.op, v.sub, v.a, v.b);
            do_op(v, $sformatf("rnd%0d", i));
        end

        // start held high across done: second op accepted as done drops
        op_i = 4'd2; sub_i = 1'b0; a_i = 32'd1; b_i = 32'd2; start_i = 1'b1;
        @(posedge clk); #1;
        a_i = 32'd10;
        @(posedge clk); #1;
        chk("b2b done1", {31'd0, done_o}, 32'd1);
        chk("b2b res1", resultado_o, 32'd3);
        chk("b2b busy1", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("b2b done_low", {31'd0, done_o}, 32'd0);
        chk("b2b busy2", {31'd0, busy_o}, 32'd1);
        @(posedge clk); #1;
        chk("b2b done2", {31'd0, done_o}, 32'd1);
        chk("b2b res2", resultado_o, 32'd12);
        @(posedge clk); #1;

        // start pulsed while shifting is ignored
        op_i = 4'd6; a_i = 32'h0000_FF00; b_i = 32'd8; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        dones = 0; first_done = -1; res_at_done = 32'd0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) begin
                start_i = 1'b1; op_i = 4'd2; a_i = 32'd1; b_i = 32'd1;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
            if (done_o === 1'b1) begin
                dones++;
                if (first_done < 0) begin
                    first_done  = c;
                    res_at_done = resultado_o;
                end
            end
        end
        chk("busy_ign dones", dones, 32'd1);
        chk("busy_ign lat", first_done, 32'd9);
        chk("busy_ign res", res_at_done, 32'h0000_00FF);

        // reset in the middle of a long SLL
        op_i = 4'd7; a_i = 32'd3; b_i = 32'd20; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid busy_pre", {31'd0, busy_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("mid busy", {31'd0, busy_o}, 32'd0);
        chk("mid done", {31'd0, done_o}, 32'd0);
        chk("mid res", resultado_o, 32'd0);
        chk("mid zero", {31'd0, zero_o}, 32'd1);
        @(negedge clk);
        rst_ni = 1'b1;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) dones++;
        end
        chk("mid no_done", dones, 32'd0);
        chk("mid res_hold", resultado_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
